// File: rtl/lwe_encrypt_accum.sv
// LWE encryption engine: streams public-key samples in LANES-wide beats,
// sums the selected ones mod 2^CW, adds scaled m to b, streams ciphertext out.
module lwe_encrypt_accum #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int BIG_N            = 30,
  parameter int LANES            = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [PLAINTEXT_WIDTH-1:0]        plaintext,
  input  logic                              abort,
  output logic                              busy,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0] in_data,
  input  logic                              in_select,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*CIPHERTEXT_WIDTH-1:0] out_data,
  output logic                              out_last
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int NE    = DIMENSION + 1;
  localparam int BEATS = (NE + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = (BIG_N > 1) ? $clog2(BIG_N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [PW-1:0] m_q, m_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] acc_q [NE];
  logic [CW-1:0] acc_d [NE];

  logic          last_beat;
  logic          last_smp;
  logic          sel_eff;
  logic [CW-1:0] m_ext;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign last_smp  = (smp_q == SW'(BIG_N - 1));
  // select is only honoured on beat 0, then held for the rest of the sample
  assign sel_eff   = (beat_q == '0) ? in_select : sel_q;
  assign m_ext     = {m_q, {(CW-PW){1'b0}}};

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && last_beat;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    smp_d   = smp_q;
    m_d     = m_q;
    sel_d   = sel_q;
    for (int e = 0; e < NE; e++) acc_d[e] = acc_q[e];
    if (abort) begin
      state_d = IDLE;
      beat_d  = '0;
      smp_d   = '0;
      m_d     = '0;
      sel_d   = 1'b0;
      for (int e = 0; e < NE; e++) acc_d[e] = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACCUM;
            m_d     = plaintext;
            beat_d  = '0;
            smp_d   = '0;
            sel_d   = 1'b0;
            for (int e = 0; e < NE; e++) acc_d[e] = '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (beat_q == '0) sel_d = in_select;
            for (int e = 0; e < NE; e++) begin
              if (beat_q == BW'(e / LANES)) begin
                if (sel_eff)
                  acc_d[e] = acc_q[e] + in_data[(e % LANES)*CW +: CW];
                if (e == NE - 1 && last_smp)
                  acc_d[e] = acc_d[e] + m_ext;
              end
            end
            if (last_beat) begin
              beat_d = '0;
              if (last_smp) begin
                smp_d   = '0;
                state_d = EMIT;
              end else begin
                smp_d = smp_q + SW'(1);
              end
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_beat) begin
              beat_d  = '0;
              state_d = IDLE;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // padding lanes of the last beat stay 0
  always_comb begin
    out_data = '0;
    if (state_q == EMIT) begin
      for (int e = 0; e < NE; e++) begin
        if (beat_q == BW'(e / LANES))
          out_data[(e % LANES)*CW +: CW] = acc_q[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      smp_q   <= '0;
      m_q     <= '0;
      sel_q   <= 1'b0;
      for (int e = 0; e < NE; e++) acc_q[e] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      smp_q   <= smp_d;
      m_q     <= m_d;
      sel_q   <= sel_d;
      for (int e = 0; e < NE; e++) acc_q[e] <= acc_d[e];
    end
  end

endmodule

// File: tb/tb_lwe_encrypt_accum.sv
// Bench for lwe_encrypt_accum: table-driven runs on a DIMENSION=3 instance,
// plus hand sequences for backpressure, abort and an odd-size instance.
module tb_lwe_encrypt_accum;

  logic clk;
  logic rst_n;

  logic        start_a, abort_a, busy_a, in_valid_a, in_ready_a;
  logic        in_select_a, out_valid_a, out_ready_a, out_last_a;
  logic [5:0]  plaintext_a;
  logic [19:0] in_data_a, out_data_a;

  logic        start_b, abort_b, busy_b, in_valid_b, in_ready_b;
  logic        in_select_b, out_valid_b, out_ready_b, out_last_b;
  logic [5:0]  plaintext_b;
  logic [19:0] in_data_b, out_data_b;

  int checks;
  int failures;

  lwe_encrypt_accum #(
    .PLAINTEXT_WIDTH(6), .CIPHERTEXT_WIDTH(10),
    .DIMENSION(3), .BIG_N(2), .LANES(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .plaintext(plaintext_a),
    .abort(abort_a), .busy(busy_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .in_data(in_data_a), .in_select(in_select_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a)
  );

  lwe_encrypt_accum #(
    .PLAINTEXT_WIDTH(6), .CIPHERTEXT_WIDTH(10),
    .DIMENSION(4), .BIG_N(1), .LANES(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .plaintext(plaintext_b),
    .abort(abort_b), .busy(busy_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_data(in_data_b), .in_select(in_select_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      m;
    logic [3:0][9:0] s0;
    logic [3:0][9:0] s1;
    logic            sel0;
    logic            sel1;
    logic            tog;
    logic [3:0][9:0] exp;
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run_a(input logic [5:0] m);
    plaintext_a = m;
    start_a     = 1'b1;
    tick();
    start_a     = 1'b0;
    chk("busy_after_start", 32'(busy_a), 32'd1);
    chk("in_ready_accum", 32'(in_ready_a), 32'd1);
  endtask

  task automatic feed_a(input logic [3:0][9:0] s, input logic sel,
                        input logic tog, input int gap);
    in_valid_a  = 1'b1;
    in_data_a   = {s[1], s[0]};
    in_select_a = sel;
    tick();
    if (gap > 0) begin
      in_valid_a  = 1'b0;
      in_data_a   = 20'hABCDE;
      in_select_a = ~sel;
      repeat (gap) tick();
    end
    in_valid_a  = 1'b1;
    in_data_a   = {s[3], s[2]};
    in_select_a = tog ? ~sel : sel;
    tick();
    in_valid_a  = 1'b0;
    in_select_a = 1'b0;
  endtask

  task automatic collect_a(input logic [3:0][9:0] exp, input int stall);
    int b;
    int cyc;
    b   = 0;
    cyc = 0;
    chk("emit_first_cycle_valid", 32'(out_valid_a), 32'd1);
    chk("in_ready_dropped", 32'(in_ready_a), 32'd0);
    while (b < 2 && cyc < 50) begin
      out_ready_a = 1'b0;
      if (out_valid_a) begin
        if (stall > 0) begin
          stall--;
          chk("stall_hold_data", 32'(out_data_a), 32'({exp[1], exp[0]}));
          chk("stall_hold_last", 32'(out_last_a), 32'd0);
        end else begin
          out_ready_a = 1'b1;
          chk($sformatf("out_data_beat%0d", b), 32'(out_data_a),
              32'({exp[2*b+1], exp[2*b]}));
          chk($sformatf("out_last_beat%0d", b), 32'(out_last_a),
              32'(b == 1));
          b++;
        end
      end
      tick();
      cyc++;
    end
    out_ready_a = 1'b0;
    if (b < 2) begin
      failures++;
      $display("FAIL collect_timeout beats=%0d required=2", b);
    end
    chk("idle_out_valid", 32'(out_valid_a), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);
  endtask

  initial begin
    logic [2:0][19:0] bd;
    logic [2:0][19:0] be;
    int               nb;
    int               cyc;

    checks   = 0;
    failures = 0;

    vt[0] = '{m: 6'd1, s0: {10'd4, 10'd3, 10'd2, 10'd1},
              s1: {10'd8, 10'd7, 10'd6, 10'd5}, sel0: 1'b1, sel1: 1'b1,
              tog: 1'b0, exp: {10'd28, 10'd10, 10'd8, 10'd6}};
    vt[1] = '{m: 6'd63, s0: {10'd1020, 10'd0, 10'd0, 10'd30},
              s1: {10'd10, 10'd0, 10'd0, 10'd1000}, sel0: 1'b1, sel1: 1'b1,
              tog: 1'b0, exp: {10'd1014, 10'd0, 10'd0, 10'd6}};
    vt[2] = '{m: 6'd0, s0: {10'd9, 10'd9, 10'd9, 10'd9},
              s1: {10'd7, 10'd7, 10'd7, 10'd7}, sel0: 1'b1, sel1: 1'b0,
              tog: 1'b1, exp: {10'd9, 10'd9, 10'd9, 10'd9}};

    rst_n = 1'b0;
    {start_a, abort_a, in_valid_a, in_select_a, out_ready_a} = '0;
    {start_b, abort_b, in_valid_b, in_select_b, out_ready_b} = '0;
    plaintext_a = '0;
    plaintext_b = '0;
    in_data_a   = '0;
    in_data_b   = '0;
    repeat (3) tick();

    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_in_ready", 32'(in_ready_a), 32'd0);
    chk("reset_out_valid", 32'(out_valid_a), 32'd0);
    chk("reset_out_last", 32'(out_last_a), 32'd0);
    chk("reset_out_data", 32'(out_data_a), 32'd0);
    chk("reset_b_busy", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      start_run_a(vt[i].m);
      feed_a(vt[i].s0, vt[i].sel0, vt[i].tog, 0);
      feed_a(vt[i].s1, vt[i].sel1, vt[i].tog, 0);
      collect_a(vt[i].exp, 0);
      tick();
    end

    // backpressure on beat 0 plus input gaps
    start_run_a(vt[0].m);
    feed_a(vt[0].s0, 1'b1, 1'b0, 2);
    in_valid_a = 1'b0;
    tick();
    feed_a(vt[0].s1, 1'b1, 1'b0, 1);
    collect_a(vt[0].exp, 3);
    tick();

    // abort mid-accumulation; start while busy must be ignored
    start_run_a(6'd5);
    in_valid_a  = 1'b1;
    in_data_a   = {10'd100, 10'd200};
    in_select_a = 1'b1;
    start_a     = 1'b1;
    plaintext_a = 6'd63;
    tick();
    start_a     = 1'b0;
    in_valid_a  = 1'b0;
    abort_a     = 1'b1;
    start_a     = 1'b1;
    tick();
    abort_a     = 1'b0;
    start_a     = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_in_ready", 32'(in_ready_a), 32'd0);
    chk("abort_out_valid", 32'(out_valid_a), 32'd0);
    start_run_a(vt[0].m);
    plaintext_a = 6'd50;
    start_a     = 1'b1;
    tick();
    start_a     = 1'b0;
    feed_a(vt[0].s0, 1'b1, 1'b0, 0);
    feed_a(vt[0].s1, 1'b1, 1'b0, 0);
    collect_a(vt[0].exp, 0);

    // odd size: DIMENSION=4, BIG_N=1, padding lane carries 999
    bd = {{10'd999, 10'd5}, {10'd4, 10'd3}, {10'd2, 10'd1}};
    be = {{10'd0, 10'd37}, {10'd4, 10'd3}, {10'd2, 10'd1}};
    plaintext_b = 6'd2;
    start_b     = 1'b1;
    tick();
    start_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid_b  = 1'b1;
      in_data_b   = bd[j];
      in_select_b = (j == 0);
      tick();
    end
    in_valid_b = 1'b0;
    chk("b_emit_valid", 32'(out_valid_b), 32'd1);
    nb  = 0;
    cyc = 0;
    while (nb < 3 && cyc < 20) begin
      out_ready_b = 1'b0;
      if (out_valid_b) begin
        out_ready_b = 1'b1;
        chk($sformatf("b_out_data_beat%0d", nb), 32'(out_data_b),
            32'(be[nb]));
        chk($sformatf("b_out_last_beat%0d", nb), 32'(out_last_b),
            32'(nb == 2));
        nb++;
      end
      tick();
      cyc++;
    end
    out_ready_b = 1'b0;
    if (nb < 3) begin
      failures++;
      $display("FAIL b_collect_timeout beats=%0d required=3", nb);
    end
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    // asynchronous reset mid-run
    start_run_a(vt[0].m);
    feed_a(vt[0].s0, 1'b1, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy_a), 32'd0);
    chk("async_reset_in_ready", 32'(in_ready_a), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("after_reset_out_valid", 32'(out_valid_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
